align_shifter: RTL
==================

ALIGN_SHIFTER -- requirements
Module: align_shifter

Interface
REQ-001 Parameter MANT_W, default 4, stored mantissa width excluding hidden bit.
REQ-002 Parameter GRD_W, default 2, guard bits appended below mantissa; OUT_W = MANT_W+GRD_W+2.
REQ-003 Parameter SHIFT_W, default 3, shift-amount width.
REQ-004 Parameter TAG_W, default 4, sideband tag width carried alongside data.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 small_mant  input  MANT_W  mantissa of smaller operand.
REQ-010 hidden  input  1  implicit leading bit (0 for denormal/zero).
REQ-011 shift_amount  input  SHIFT_W  exponent difference, unsigned.
REQ-012 tag_in  input  TAG_W  passthrough tag.
REQ-013 out_valid  output  1  output beat present.
REQ-014 out_ready  input  1  downstream accepts beat.
REQ-015 shifted_mant  output  OUT_W  aligned mantissa.
REQ-016 sticky  output  1  OR of all bits shifted below bit 0.
REQ-017 tag_out  output  TAG_W  tag of current output beat.

Function
REQ-018 Pre-shift word SHALL be {1'b0, hidden, small_mant, GRD_W zeros}; result = logical right shift by shift_amount.
REQ-019 shift_amount >= OUT_W SHALL give shifted_mant = 0, sticky = hidden | (|small_mant).
REQ-020 Stage 1 SHALL shift by shift_amount with low 2 bits cleared and register partial sticky; stage 2 SHALL shift by shift_amount[1:0] and OR further dropped bits into sticky.
REQ-021 Latency SHALL be exactly 2 cycles from accepted input to out_valid when out_ready stays high; throughput 1 beat/cycle.
REQ-022 Transfer occurs when valid & ready both high at a rising edge; out_valid, shifted_mant, sticky, tag_out SHALL stay stable while out_valid & !out_ready.
REQ-023 Stage 2 loads when empty or out_ready; stage 1 loads when empty or stage 2 loads; in_ready = stage-1 load condition (combinational from out_ready permitted).
REQ-024 Simultaneous drain and fill of a full pipeline with out_ready high SHALL lose or duplicate no beat.
REQ-025 in_valid with in_ready low SHALL not alter any stage; beats are never dropped.
REQ-026 Tag SHALL travel with its beat through both stages unchanged.

Reset
REQ-027 While rst high: both stage valid flags, out_valid, shifted_mant, sticky, tag_out SHALL be 0 at next edge; in-flight beats discarded.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-029 Macro ALIGN_SHIFTER_STICKY_EN defined: sticky computed per REQ-016/019/020 and additionally ORed into shifted_mant[0].
REQ-030 Macro undefined: sticky tied 0, no sticky logic, shifted_mant[0] is plain shift result (truncation).

Structure
REQ-031 Shared package fp_addr_pkg SHALL hold default MANT_W/GRD_W/SHIFT_W constants and the OUT_W derivation function.
REQ-032 One sub-module, align_stage, SHALL implement a single registered shift stage with valid/ready and sticky accumulation, instantiated twice.

Verification (MANT_W=4, GRD_W=2, SHIFT_W=3, STICKY_EN defined)
REQ-033 mant=4'b1011, hidden=1, shift=0, out_ready=1 -> shifted_mant=8'h6C, sticky=0, out_valid 2 cycles later.
REQ-034 Same operand, shift=3 -> shifted_mant=8'h0D, sticky=1.
REQ-035 mant=0, hidden=1, shift=7 -> shifted_mant=8'h01 (sticky ORed), sticky=1; macro undefined -> 8'h00, sticky=0.
REQ-036 Four back-to-back beats, tags 1..4, out_ready low cycles 3-5 -> no loss, order 1..4, output held stable during stall, in_ready low while both stages full.
REQ-037 rst asserted with two beats in flight -> out_valid=0 next cycle, no stale beat emitted after release.

Source files
------------

// File: rtl/fp_addr_pkg.sv
// Shared constants for the FP adder alignment path: default widths and the OUT_W derivation.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: DEF_MANT_W, DEF_GRD_W, DEF_SHIFT_W, DEF_TAG_W, out_w().
package fp_addr_pkg;

    localparam int DEF_MANT_W  = 4;
    localparam int DEF_GRD_W   = 2;
    localparam int DEF_SHIFT_W = 3;
    localparam int DEF_TAG_W   = 4;

    // Aligned word: one headroom zero, hidden bit, mantissa, guard bits.
    function automatic int out_w(input int mant_w, input int grd_w);
        return mant_w + grd_w + 2;
    endfunction

endpackage

// File: rtl/align_stage.sv
// One registered right-shift stage with valid/ready handshake and sticky accumulation.
// Latency: 1 cycle from an accepted up beat to dn_valid.
// Backpressure: loads when empty or dn_ready; up_ready = load condition (combinational from dn_ready).
// Ports: clk, rst (sync, active-high); up_* = incoming beat (word, shift, sideband, sticky);
//        dn_* = registered beat. Sticky ports exist only with ALIGN_SHIFTER_STICKY_EN defined.
module align_stage #(
    parameter int W       = 8,
    parameter int SHIFT_W = 3,
    parameter int SIDE_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up_valid,
    output logic               up_ready,
    input  logic [W-1:0]       up_word,
    input  logic [SHIFT_W-1:0] up_shift,
    input  logic [SIDE_W-1:0]  up_side,
`ifdef ALIGN_SHIFTER_STICKY_EN
    input  logic               up_sticky,
    output logic               dn_sticky,
`endif
    output logic               dn_valid,
    input  logic               dn_ready,
    output logic [W-1:0]       dn_word,
    output logic [SIDE_W-1:0]  dn_side
);

    logic         load;
    logic [W-1:0] shifted;

    // Register is free when empty or its current beat leaves this edge.
    assign load     = !dn_valid || dn_ready;
    assign up_ready = load;

    // A shift of W or more yields zero, which is the required saturation.
    assign shifted = up_word >> up_shift;

`ifdef ALIGN_SHIFTER_STICKY_EN
    logic [W-1:0] low_mask;
    logic         dropped;

    // Mask of the bit positions falling off the bottom; all ones once shift >= W.
    assign low_mask = ~({W{1'b1}} << up_shift);
    assign dropped  = |(up_word & low_mask);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            dn_valid  <= 1'b0;
            dn_word   <= '0;
            dn_side   <= '0;
`ifdef ALIGN_SHIFTER_STICKY_EN
            dn_sticky <= 1'b0;
`endif
        end else if (load) begin
            dn_valid <= up_valid;
            // Payload only changes when a real beat arrives, so a bubble leaves it untouched.
            if (up_valid) begin
                dn_word   <= shifted;
                dn_side   <= up_side;
`ifdef ALIGN_SHIFTER_STICKY_EN
                dn_sticky <= up_sticky | dropped;
`endif
            end
        end
    end

endmodule

// File: rtl/align_shifter.sv
// Aligns the smaller FP operand's mantissa: right shift by exponent difference with sticky.
// Latency: 2 cycles (coarse shift by multiples of 4, then fine shift by shift_amount[1:0]); 1 beat/cycle.
// Backpressure: valid/ready; in_ready is combinational from out_ready through both stage load terms.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, small_mant, hidden, shift_amount, tag_in;
//        out_valid/out_ready, shifted_mant, sticky, tag_out.
// Config: ALIGN_SHIFTER_STICKY_EN defined -> sticky computed and ORed into shifted_mant[0];
//         undefined -> sticky tied 0, plain truncating shift.
module align_shifter
    import fp_addr_pkg::*;
#(
    parameter int MANT_W  = DEF_MANT_W,
    parameter int GRD_W   = DEF_GRD_W,
    parameter int SHIFT_W = DEF_SHIFT_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MANT_W-1:0]         small_mant,
    input  logic                      hidden,
    input  logic [SHIFT_W-1:0]        shift_amount,
    input  logic [TAG_W-1:0]          tag_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MANT_W+GRD_W+1:0]   shifted_mant,
    output logic                      sticky,
    output logic [TAG_W-1:0]          tag_out
);

    localparam int OUT_W   = out_w(MANT_W, GRD_W);
    localparam int SIDE1_W = TAG_W + 2;

    logic [OUT_W-1:0]   pre_word;
    logic [SHIFT_W-1:0] coarse_shift;
    logic [SIDE1_W-1:0] s1_side_in;

    logic               s1_valid;
    logic               s1_ready;
    logic [OUT_W-1:0]   s1_word;
    logic [SIDE1_W-1:0] s1_side;
    logic [SHIFT_W-1:0] fine_shift;

    logic [OUT_W-1:0]   s2_word;

    assign pre_word     = {1'b0, hidden, small_mant, {GRD_W{1'b0}}};
    assign coarse_shift = shift_amount & ~SHIFT_W'(3);
    // The fine shift amount rides along with the tag into stage 2.
    assign s1_side_in   = {shift_amount[1:0], tag_in};
    assign fine_shift   = SHIFT_W'(s1_side[TAG_W +: 2]);

`ifdef ALIGN_SHIFTER_STICKY_EN
    logic s1_sticky;
    logic s2_sticky;
`endif

    align_stage #(
        .W       (OUT_W),
        .SHIFT_W (SHIFT_W),
        .SIDE_W  (SIDE1_W)
    ) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (in_valid),
        .up_ready  (in_ready),
        .up_word   (pre_word),
        .up_shift  (coarse_shift),
        .up_side   (s1_side_in),
`ifdef ALIGN_SHIFTER_STICKY_EN
        .up_sticky (1'b0),
        .dn_sticky (s1_sticky),
`endif
        .dn_valid  (s1_valid),
        .dn_ready  (s1_ready),
        .dn_word   (s1_word),
        .dn_side   (s1_side)
    );

    align_stage #(
        .W       (OUT_W),
        .SHIFT_W (SHIFT_W),
        .SIDE_W  (TAG_W)
    ) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (s1_valid),
        .up_ready  (s1_ready),
        .up_word   (s1_word),
        .up_shift  (fine_shift),
        .up_side   (s1_side[TAG_W-1:0]),
`ifdef ALIGN_SHIFTER_STICKY_EN
        .up_sticky (s1_sticky),
        .dn_sticky (s2_sticky),
`endif
        .dn_valid  (out_valid),
        .dn_ready  (out_ready),
        .dn_word   (s2_word),
        .dn_side   (tag_out)
    );

`ifdef ALIGN_SHIFTER_STICKY_EN
    // Jamming sticky into the LSB keeps rounding information in the word itself.
    assign shifted_mant = {s2_word[OUT_W-1:1], s2_word[0] | s2_sticky};
    assign sticky       = s2_sticky;
`else
    assign shifted_mant = s2_word;
    assign sticky       = 1'b0;
`endif

endmodule
